// File: rtl/align_shifter_seq_pkg.sv
// -----------------------------------------------------------------------------
// align_shifter_seq_pkg
//
// Purpose:
//   Shared constants and types for the iterative significand alignment stage.
//   Holds the significand / guard-round-sticky widths and saturation limits for
//   the single and half precision formats, the default per-cycle shift step,
//   and the FSM state encoding used by align_shifter_seq.
//
// Contents:
//   SingleMantSize / SingleMaxShift : single precision significand width and
//                                     shift saturation limit (MantSize + 3)
//   HalfMantSize   / HalfMaxShift   : same for half precision
//   GrsWidth                        : number of guard/round/sticky bits
//   DefaultStepSize                 : bits shifted per SHIFT cycle
//   state_e                         : IDLE / SHIFT / DONE
// -----------------------------------------------------------------------------
package align_shifter_seq_pkg;

  localparam int GrsWidth        = 3;

  localparam int SingleMantSize  = 24;
  localparam int SingleMaxShift  = SingleMantSize + GrsWidth;

  localparam int HalfMantSize    = 11;
  localparam int HalfMaxShift    = HalfMantSize + GrsWidth;

  localparam int DefaultStepSize = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage : align_shifter_seq_pkg

// File: rtl/align_shifter_seq_sticky_right_shift.sv
// -----------------------------------------------------------------------------
// sticky_right_shift
//
// Purpose:
//   Combinational right shift by a small amount that folds every bit shifted
//   out into bit 0 of the result, so sticky information is never lost across
//   successive partial shifts.
//
// Ports:
//   data_i  [Width-1:0]  : value to shift ({significand, G, R, S})
//   k_i     [KWidth-1:0] : shift amount for this step
//   data_o  [Width-1:0]  : data_i >> k_i with bit 0 ORed with the lost bits
// -----------------------------------------------------------------------------
module sticky_right_shift #(
  parameter int Width  = 27,
  parameter int KWidth = 3
) (
  input  logic [Width-1:0]  data_i,
  input  logic [KWidth-1:0] k_i,
  output logic [Width-1:0]  data_o
);

  logic [Width-1:0] shifted;
  logic [Width-1:0] lostMask;
  logic             sticky;

  // lostMask selects exactly the k_i low bits that fall off the right end;
  // any 1 among them sets the sticky position of the shifted result.
  always_comb begin
    shifted  = data_i >> k_i;
    lostMask = ~({Width{1'b1}} << k_i);
    sticky   = |(data_i & lostMask);
    data_o   = {shifted[Width-1:1], shifted[0] | sticky};
  end

endmodule : sticky_right_shift

// File: rtl/align_shifter_seq.sv
// -----------------------------------------------------------------------------
// align_shifter_seq
//
// Purpose:
//   Alignment stage of the floating-point adder. Passes the larger-exponent
//   significand straight through and right-shifts the smaller one by the
//   (re-clamped) exponent difference, producing {significand, G, R, S}.
//   The shift is done iteratively, at most StepSize bits per cycle, under a
//   three-state FSM with valid/ready handshakes on both sides.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-high reset
//   InValid      in   upstream operands valid
//   InReady      out  stage can accept (IDLE and not in reset)
//   Mantissa1    in   significand of operand 1 (hidden bit included)
//   Mantissa2    in   significand of operand 2 (hidden bit included)
//   Difference   in   unsigned exponent difference
//   Sign         in   1: shift Mantissa2, 0: shift Mantissa1
//   OutValid     out  aligned result valid (DONE)
//   OutReady     in   downstream accepts result
//   LargeMant    out  unshifted larger-exponent significand
//   AlignedMant  out  shifted significand {mantissa, G, R, S}
//   Swapped      out  1 when operand 1 was the shifted one
// -----------------------------------------------------------------------------
module align_shifter_seq
  import align_shifter_seq_pkg::*;
#(
  parameter int MantSize  = SingleMantSize,
  parameter int ShiftSize = 5,
  parameter int MaxShift  = SingleMaxShift,
  parameter int StepSize  = DefaultStepSize
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic [MantSize-1:0]         Mantissa1,
  input  logic [MantSize-1:0]         Mantissa2,
  input  logic [ShiftSize-1:0]        Difference,
  input  logic                        Sign,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [MantSize-1:0]         LargeMant,
  output logic [MantSize+GrsWidth-1:0] AlignedMant,
  output logic                        Swapped
);

  localparam int WorkWidth = MantSize + GrsWidth;
  localparam int RemWidth  = $clog2(MaxShift + 1);
  localparam int KWidth    = $clog2(StepSize + 1);

  state_e               state_q, state_d;
  logic [MantSize-1:0]  large_q, large_d;
  logic [WorkWidth-1:0] work_q, work_d;
  logic [RemWidth-1:0]  remaining_q, remaining_d;
  logic                 swapped_q, swapped_d;

  logic [RemWidth-1:0]  clampedShift;
  logic [KWidth-1:0]    stepAmount;
  logic [RemWidth-1:0]  remainingAfterStep;
  logic [WorkWidth-1:0] workShifted;

  // Upstream already saturates the difference, but it is re-clamped here so
  // any value above MaxShift behaves exactly like MaxShift.
  always_comb begin
    if (int'(Difference) > MaxShift) begin
      clampedShift = RemWidth'(MaxShift);
    end else begin
      clampedShift = RemWidth'(Difference);
    end
  end

  // Each SHIFT cycle moves min(remaining, StepSize) bits.
  always_comb begin
    if (remaining_q > RemWidth'(StepSize)) begin
      stepAmount = KWidth'(StepSize);
    end else begin
      stepAmount = KWidth'(remaining_q);
    end
    remainingAfterStep = remaining_q - RemWidth'(stepAmount);
  end

  sticky_right_shift #(
    .Width  (WorkWidth),
    .KWidth (KWidth)
  ) u_sticky_right_shift (
    .data_i (work_q),
    .k_i    (stepAmount),
    .data_o (workShifted)
  );

  // Next-state and datapath update. Outputs are plain copies of the
  // registers, so they cannot change while the FSM waits in DONE.
  always_comb begin
    state_d     = state_q;
    large_d     = large_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    swapped_d   = swapped_q;

    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          if (Sign) begin
            large_d   = Mantissa1;
            work_d    = {Mantissa2, {GrsWidth{1'b0}}};
            swapped_d = 1'b0;
          end else begin
            large_d   = Mantissa2;
            work_d    = {Mantissa1, {GrsWidth{1'b0}}};
            swapped_d = 1'b1;
          end
          remaining_d = clampedShift;
          state_d     = (clampedShift == '0) ? StDone : StShift;
        end
      end

      StShift: begin
        work_d      = workShifted;
        remaining_d = remainingAfterStep;
        if (remainingAfterStep == '0) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (OutReady) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      large_q     <= '0;
      work_q      <= '0;
      remaining_q <= '0;
      swapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      large_q     <= large_d;
      work_q      <= work_d;
      remaining_q <= remaining_d;
      swapped_q   <= swapped_d;
    end
  end

  // InReady is gated with Reset so nothing is offered while reset is held.
  assign InReady     = (state_q == StIdle) & ~Reset;
  assign OutValid    = (state_q == StDone);
  assign LargeMant   = large_q;
  assign AlignedMant = work_q;
  assign Swapped     = swapped_q;

endmodule : align_shifter_seq

// File: tb/tb_align_shifter_seq.sv
// -----------------------------------------------------------------------------
// tb_align_shifter_seq
//
// Purpose:
//   Self-checking bench for align_shifter_seq. Directed cases from the block's
//   intended behaviour plus randomized operations, all compared against a
//   plain-arithmetic reference of the alignment (one-shot shift with sticky).
// -----------------------------------------------------------------------------
module tb_align_shifter_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [23:0] Mantissa1 = '0;
  logic [23:0] Mantissa2 = '0;
  logic [4:0]  Difference = '0;
  logic        Sign = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [23:0] LargeMant;
  logic [26:0] AlignedMant;
  logic        Swapped;

  int nChecks = 0;
  int nFail   = 0;

  logic [23:0] expLarge;
  logic [26:0] expAligned;
  logic        expSwapped;
  int          expLatency;

  align_shifter_seq dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .Mantissa1   (Mantissa1),
    .Mantissa2   (Mantissa2),
    .Difference  (Difference),
    .Sign        (Sign),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .LargeMant   (LargeMant),
    .AlignedMant (AlignedMant),
    .Swapped     (Swapped)
  );

  always #5 Clk = ~Clk;

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: align in one arithmetic step on a wide integer, with every
  // bit lost below the GRS positions collapsed into the sticky bit.
  task automatic computeExpected(input logic [23:0] m1, input logic [23:0] m2,
                                 input int d, input logic s);
    int dc;
    longint unsigned full, kept, lost;
    dc   = (d > 27) ? 27 : d;
    full = s ? {37'd0, m2, 3'b000} : {37'd0, m1, 3'b000};
    kept = full >> dc;
    lost = full - (kept << dc);
    if (lost != 0) kept = kept | 64'd1;
    expAligned = kept[26:0];
    expLarge   = s ? m1 : m2;
    expSwapped = ~s;
    expLatency = 1 + (dc + 3) / 4;
  endtask

  // Present an operand set and wait (bounded) for the accepting edge.
  // Returns #1 after that edge with InValid dropped.
  task automatic applyStimulus(input logic [23:0] m1, input logic [23:0] m2,
                               input logic [4:0] d, input logic s);
    int waitCycles;
    Mantissa1  = m1;
    Mantissa2  = m2;
    Difference = d;
    Sign       = s;
    InValid    = 1'b1;
    computeExpected(m1, m2, int'(d), s);
    waitCycles = 0;
    while (!InReady && waitCycles < 50) begin
      @(posedge Clk); #1;
      waitCycles++;
    end
    checkOutput("accept_ready", {31'd0, InReady}, 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  // Wait (bounded) for OutValid after the accepting edge and check result.
  task automatic waitResult(input string tag);
    int cycles;
    cycles = 1;
    while (!OutValid && cycles < 60) begin
      @(posedge Clk); #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, expLatency);
    checkOutput({tag, "_large"}, {8'd0, LargeMant}, {8'd0, expLarge});
    checkOutput({tag, "_aligned"}, {5'd0, AlignedMant}, {5'd0, expAligned});
    checkOutput({tag, "_swapped"}, {31'd0, Swapped}, {31'd0, expSwapped});
    checkOutput({tag, "_inready_busy"}, {31'd0, InReady}, 32'd0);
  endtask

  // Hand the result downstream and confirm return to IDLE.
  task automatic releaseResult(input string tag);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    checkOutput({tag, "_outvalid_drop"}, {31'd0, OutValid}, 32'd0);
    checkOutput({tag, "_inready_back"}, {31'd0, InReady}, 32'd1);
  endtask

  initial begin
    logic [23:0] rm1, rm2;
    logic [4:0]  rd;
    logic        rs;
    int          hold;

    // Reset state
    #1;
    checkOutput("rst_inready", {31'd0, InReady}, 32'd0);
    checkOutput("rst_outvalid", {31'd0, OutValid}, 32'd0);
    checkOutput("rst_aligned", {5'd0, AlignedMant}, 32'd0);
    checkOutput("rst_large", {8'd0, LargeMant}, 32'd0);
    checkOutput("rst_swapped", {31'd0, Swapped}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checkOutput("rst_release_inready", {31'd0, InReady}, 32'd1);
    @(posedge Clk); #1;

    // Plan 1: single-bit shift
    applyStimulus(24'h800000, 24'hC00001, 5'd1, 1'b1);
    waitResult("p1");
    checkOutput("p1_literal", {5'd0, AlignedMant}, 32'h3000004);
    releaseResult("p1");

    // Plan 2: zero shift, operands swapped
    applyStimulus(24'h123456, 24'hABCDEF, 5'd0, 1'b0);
    waitResult("p2");
    checkOutput("p2_literal", {5'd0, AlignedMant}, 32'h091A2B0);
    releaseResult("p2");

    // Plan 3: sticky collects lost ones
    applyStimulus(24'h800000, 24'hFFFFFF, 5'd5, 1'b1);
    waitResult("p3");
    checkOutput("p3_literal", {5'd0, AlignedMant}, 32'h03FFFFF);
    releaseResult("p3");

    // Plan 4: full saturation, 27 and 31 behave alike
    applyStimulus(24'h800000, 24'h000001, 5'd27, 1'b1);
    waitResult("p4a");
    checkOutput("p4a_literal", {5'd0, AlignedMant}, 32'h0000001);
    releaseResult("p4a");
    applyStimulus(24'h800000, 24'h000001, 5'd31, 1'b1);
    waitResult("p4b");
    checkOutput("p4b_literal", {5'd0, AlignedMant}, 32'h0000001);
    releaseResult("p4b");

    // All-zero significand keeps sticky clear
    applyStimulus(24'h9ABCDE, 24'h000000, 5'd13, 1'b1);
    waitResult("zero");
    releaseResult("zero");

    // Plan 5: backpressure with a new operand waiting
    applyStimulus(24'hF00000, 24'hA5A5A5, 5'd9, 1'b0);
    waitResult("p5");
    Mantissa1  = 24'h111111;
    Mantissa2  = 24'h222222;
    Difference = 5'd2;
    Sign       = 1'b1;
    InValid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      checkOutput("p5_hold_valid", {31'd0, OutValid}, 32'd1);
      checkOutput("p5_hold_aligned", {5'd0, AlignedMant}, {5'd0, expAligned});
      checkOutput("p5_hold_large", {8'd0, LargeMant}, {8'd0, expLarge});
      checkOutput("p5_hold_inready", {31'd0, InReady}, 32'd0);
    end
    releaseResult("p5");
    applyStimulus(24'h111111, 24'h222222, 5'd2, 1'b1);
    waitResult("p5_next");
    releaseResult("p5_next");

    // Plan 6: reset in the middle of a shift
    applyStimulus(24'h800000, 24'hFFFFFF, 5'd20, 1'b1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    checkOutput("p6_rst_outvalid", {31'd0, OutValid}, 32'd0);
    checkOutput("p6_rst_aligned", {5'd0, AlignedMant}, 32'd0);
    checkOutput("p6_rst_large", {8'd0, LargeMant}, 32'd0);
    checkOutput("p6_rst_inready", {31'd0, InReady}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    checkOutput("p6_release_inready", {31'd0, InReady}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      checkOutput("p6_no_pulse", {31'd0, OutValid}, 32'd0);
    end
    applyStimulus(24'h345678, 24'h876543, 5'd0, 1'b1);
    waitResult("p6_after");
    releaseResult("p6_after");

    // Randomized operations with random downstream stalls
    for (int n = 0; n < 30; n++) begin
      rm1 = 24'($urandom) | 24'h800000;
      rm2 = 24'($urandom);
      if (($urandom % 4) != 0) rm2 = rm2 | 24'h800000;
      rd  = 5'($urandom_range(0, 31));
      rs  = 1'($urandom);
      applyStimulus(rm1, rm2, rd, rs);
      waitResult("rnd");
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge Clk); #1;
        checkOutput("rnd_stall_aligned", {5'd0, AlignedMant}, {5'd0, expAligned});
      end
      releaseResult("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule : tb_align_shifter_seq

// File: doc/align_shifter_seq.md
Name: align_shifter_seq

Overview:
Alignment stage that consumes the saturated shift amount and operand-order flag from the exponent-difference stage. Takes the two significands (hidden bit included) and routes the larger-exponent one straight through. Right-shifts the smaller one by the shift amount, producing guard/round/sticky bits for the add/sub core downstream.
Iterative: shifts at most StepSize bits per cycle under a small FSM, with valid/ready handshakes on input and output.

Parameters:
MantSize, 24, significand width including hidden bit (single precision)
ShiftSize, 5, width of the Difference input
MaxShift, 27, saturation limit of the shift amount (MantSize+3)
StepSize, 4, maximum bits shifted per SHIFT cycle (1..8)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
InValid  input  1  upstream operands/shift amount valid
InReady  output  1  block can accept (IDLE only)
Mantissa1  input  MantSize  significand of operand 1
Mantissa2  input  MantSize  significand of operand 2
Difference  input  ShiftSize  unsigned exponent difference (already saturated upstream; re-clamped here)
Sign  input  1  1: Exponent1>=Exponent2 (shift Mantissa2); 0: Exponent2>Exponent1 (shift Mantissa1)
OutValid  output  1  aligned result valid
OutReady  input  1  downstream accepts result
LargeMant  output  MantSize  unshifted significand of larger-exponent operand
AlignedMant  output  MantSize+3  shifted significand {mantissa, G, R, S}
Swapped  output  1  1 when operand 1 was the shifted one (= ~Sign at capture)

Behaviour:
- Clock and reset: single clock Clk; Reset is asynchronous and active-high.
- Reset: state=IDLE; LargeMant, AlignedMant, Swapped, OutValid = 0; Remaining = 0. InReady=0 while Reset is high and 1 in the first cycle after release.
- States: IDLE, SHIFT, DONE. InReady = (state==IDLE) & ~Reset. OutValid = (state==DONE).
- IDLE, on InValid&InReady:
  - Sign=1: LargeMant<=Mantissa1, W<={Mantissa2,3'b000}, Swapped<=0.
  - Sign=0: LargeMant<=Mantissa1 swapped out for Mantissa2, i.e. LargeMant<=Mantissa2, W<={Mantissa1,3'b000}, Swapped<=1.
  - Remaining <= min(Difference, MaxShift).
  - Next state DONE if the clamped amount is 0, else SHIFT.
- SHIFT, each cycle:
  - k = min(Remaining, StepSize).
  - W <= (W >> k), with bit0 of the result ORed with the OR of the k bits shifted out (sticky is never lost).
  - Remaining <= Remaining-k.
  - Go to DONE when Remaining-k == 0.
- AlignedMant is W, registered. Outputs stay stable throughout DONE.
- DONE: hold all outputs until OutReady=1, then go to IDLE. No new accept in the same cycle, so at least one bubble per operation.
- Latency: accept edge to OutValid high = 1 + ceil(Dc/StepSize) cycles, where Dc is the clamped shift amount.
- Clamping: Difference values 28..31 behave exactly as 27. With Dc=27 the whole significand lands in sticky: AlignedMant = 0 or 1.
- Boundaries:
  - InValid while busy is ignored; upstream must hold it.
  - OutReady high outside DONE has no effect.
  - Reset mid-SHIFT or mid-DONE aborts immediately to reset values; the partial result is discarded and never presented.
  - Mantissa all-zero gives AlignedMant = 0 with sticky 0.

Decomposition:
- Shared package: MantSize/GRS width (3)/MaxShift constants for the single and half formats, and the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- One combinational sub-module, sticky_right_shift: inputs W and k; outputs the shifted W with sticky OR-merge. The FSM/handshake stays in the top module.

Test Plan:
1. Sign=1, M1=24'h800000, M2=24'hC00001, D=1 -> after 2 cycles OutValid=1, LargeMant=24'h800000, AlignedMant=27'h3000004, Swapped=0.
2. Sign=0, M1=24'h123456, M2=24'hABCDEF, D=0 -> after 1 cycle LargeMant=24'hABCDEF, AlignedMant=27'h091A2B0, Swapped=1.
3. Sign=1, M2=24'hFFFFFF, D=5 -> after 3 cycles AlignedMant=27'h03FFFFF (sticky=1).
4. Sign=1, M2=24'h000001, D=27 and again with D=31 -> both after 8 cycles AlignedMant=27'h0000001.
5. Backpressure: OutReady=0 for 4 cycles in DONE, InValid=1 with new data -> outputs unchanged, InReady=0, no capture. Release OutReady -> IDLE, then the new operand is accepted.
6. Assert Reset during SHIFT (D=20, cycle 3) -> all outputs 0 immediately, no OutValid pulse. After release, a D=0 operation completes normally in 1 cycle.
